// File: rtl/fair_home_scheduler.sv
// Round-robin owner of the home actuator/display path with bounded dwell and bounded fire preemption.
// Latency: input captured at edge k, grant visible after edge k+1; no backpressure, requests are levels.
module fair_home_scheduler #(
   parameter int unsigned DWELL        = 4,
   parameter int unsigned T_LOW        = 50,
   parameter int unsigned T_HIGH       = 80,
   parameter bit          FIRE_PREEMPT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sfd,
   input  logic       srd,
   input  logic       sw,
   input  logic       sfa,
   input  logic [6:0] st,
   output logic       fdoor,
   output logic       rdoor,
   output logic       winbuzz,
   output logic       alarambuzz,
   output logic       heater,
   output logic       cooler,
   output logic [2:0] display,
   output logic       busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);
   localparam logic [2:0] FIRE     = 3'd3;
   localparam logic [6:0] T_LOW_V  = 7'(T_LOW);
   localparam logic [6:0] T_HIGH_V = 7'(T_HIGH);

   function automatic logic [2:0] wrap_inc(input logic [2:0] i);
      return (i == 3'd5) ? 3'd0 : i + 3'd1;
   endfunction

   // Returns {found, index} of the first set bit scanning from start, wrapping mod 6.
   function automatic logic [3:0] pick(input logic [5:0] req, input logic [2:0] start);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      idx = start;
      for (int k = 0; k < 6; k++) begin
         if (!res[3] && req[idx]) res = {1'b1, idx};
         idx = wrap_inc(idx);
      end
      return res;
   endfunction

   state_t     state, state_n;
   logic [5:0] req_q;
   logic [2:0] g, g_n;
   logic [3:0] cnt, cnt_n;
   logic [2:0] ptr, ptr_n;
   logic       lockout, lock_n;
   logic       pre, pre_n;
   logic [5:0] grant_q, grant_n;
   logic [2:0] disp_n;

   logic       expired;
   logic [2:0] rel_ptr;
   logic [5:0] mask;
   logic [3:0] cand;
   logic [3:0] first;

   assign expired = (cnt == 4'd0);
   // A preempting fire grant hands the path back to the requester it aborted.
   assign rel_ptr = (pre && g == FIRE) ? ptr : wrap_inc(g);
   assign mask    = expired ? (req_q & ~(6'b000001 << g)) : req_q;
   assign cand    = pick(mask, rel_ptr);
   assign first   = pick(req_q, ptr);

   always_comb begin
      state_n = state;
      g_n     = g;
      cnt_n   = cnt;
      ptr_n   = ptr;
      lock_n  = lockout;
      pre_n   = pre;
      case (state)
         IDLE: begin
            if (first[3]) begin
               state_n = GRANT;
               g_n     = first[2:0];
               cnt_n   = CNT_LOAD;
               pre_n   = 1'b0;
            end
         end
         default: begin
            if (FIRE_PREEMPT && g != FIRE && req_q[FIRE] && !lockout) begin
               g_n   = FIRE;
               cnt_n = CNT_LOAD;
               ptr_n = g;
               pre_n = 1'b1;
            end else if (!req_q[g] || expired) begin
               ptr_n  = rel_ptr;
               lock_n = (g == FIRE);
               pre_n  = 1'b0;
               if (cand[3]) begin
                  g_n   = cand[2:0];
                  cnt_n = CNT_LOAD;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
      endcase
      grant_n = (state_n == GRANT) ? (6'b000001 << g_n) : 6'b000000;
      disp_n  = (state_n == GRANT) ? (g_n + 3'd1) : 3'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         req_q   <= 6'd0;
         g       <= 3'd0;
         cnt     <= 4'd0;
         ptr     <= 3'd0;
         lockout <= 1'b0;
         pre     <= 1'b0;
         grant_q <= 6'd0;
         display <= 3'd0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         req_q   <= {st > T_HIGH_V, st < T_LOW_V, sfa, sw, srd, sfd};
         g       <= g_n;
         cnt     <= cnt_n;
         ptr     <= ptr_n;
         lockout <= lock_n;
         pre     <= pre_n;
         grant_q <= grant_n;
         display <= disp_n;
         busy    <= (state_n == GRANT);
      end
   end

   assign fdoor      = grant_q[0];
   assign rdoor      = grant_q[1];
   assign winbuzz    = grant_q[2];
   assign alarambuzz = grant_q[3];
   assign heater     = grant_q[4];
   assign cooler     = grant_q[5];

endmodule

// File: tb/tb_fair_home_scheduler.sv
// Directed bench for fair_home_scheduler: reset, rotation, early drop, thresholds, preemption, full load.
module tb_fair_home_scheduler;

   logic       clk;
   logic       rst;
   logic       sfd, srd, sw, sfa;
   logic [6:0] st;
   logic       fdoor, rdoor, winbuzz, alarambuzz, heater, cooler;
   logic [2:0] display;
   logic       busy;

   int n_vec;
   int n_bad;

   fair_home_scheduler #(
      .DWELL(4), .T_LOW(50), .T_HIGH(80), .FIRE_PREEMPT(1'b1)
   ) dut (
      .clk(clk), .rst(rst),
      .sfd(sfd), .srd(srd), .sw(sw), .sfa(sfa), .st(st),
      .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz), .alarambuzz(alarambuzz),
      .heater(heater), .cooler(cooler), .display(display), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [5:0] grants  = {cooler, heater, alarambuzz, winbuzz, rdoor, fdoor};
   wire [9:0] obs_all = {busy, display, grants};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // idx 0..5 = that grant active, anything else = idle
   function automatic logic [9:0] exp_vec(input int idx);
      logic [5:0] oh;
      if (idx < 0 || idx > 5) return 10'd0;
      oh = 6'b000001 << idx;
      return {1'b1, 3'(idx + 1), oh};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sfd = 1'b0; srd = 1'b0; sw = 1'b0; sfa = 1'b0;
      st  = 7'd65;
      @(negedge clk);
      rst = 1'b1;
   endtask

   int rot_exp [16];
   int pre_exp [17] = '{2, 3, 3, 3, 3, 2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 2};
   int temp_st [7]  = '{30, 100, 50, 80, 65, 49, 81};
   int temp_exp[7]  = '{4, 5, -1, -1, -1, 4, 5};

   initial begin
      int gap[4];
      int maxgap;
      bit seen[4];
      logic [5:0] ever;
      logic [2:0] prev_disp;
      logic [3:0] exp_bd;

      n_vec = 0;
      n_bad = 0;
      rst = 1'b0;
      sfd = 1'b0; srd = 1'b0; sw = 1'b0; sfa = 1'b0;
      st  = 7'd65;

      // reset state, first-grant latency, async reset mid-grant
      @(negedge clk);
      check("rst_state", obs_all, 10'd0);
      rst = 1'b1;
      sfd = 1'b1;
      step();
      check("rst_lat_idle", obs_all, exp_vec(-1));
      step();
      check("rst_lat_grant", obs_all, exp_vec(0));
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("rst_async", obs_all, 10'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      check("rst_re_idle", obs_all, exp_vec(-1));
      step();
      check("rst_re_grant", obs_all, exp_vec(0));

      // two-way rotation with back-to-back grants
      for (int i = 0; i < 16; i++) rot_exp[i] = ((i / 4) % 2 == 0) ? 0 : 2;
      do_reset();
      sfd = 1'b1;
      sw  = 1'b1;
      step();
      check("rot_idle", obs_all, exp_vec(-1));
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("rot_%0d", i), obs_all, exp_vec(rot_exp[i]));
      end

      // early drop after two cycles of request
      do_reset();
      srd = 1'b1;
      step();
      check("drop_idle0", obs_all, exp_vec(-1));
      step();
      srd = 1'b0;
      check("drop_g0", obs_all, exp_vec(1));
      step();
      check("drop_g1", obs_all, exp_vec(1));
      step();
      check("drop_idle1", obs_all, exp_vec(-1));
      step();
      check("drop_idle2", obs_all, exp_vec(-1));

      // temperature thresholds, including the exact boundaries
      for (int t = 0; t < 7; t++) begin
         do_reset();
         st = 7'(temp_st[t]);
         step();
         check($sformatf("temp_%0d_lat", temp_st[t]), obs_all, exp_vec(-1));
         step();
         check($sformatf("temp_%0d_a", temp_st[t]), obs_all, exp_vec(temp_exp[t]));
         step();
         check($sformatf("temp_%0d_b", temp_st[t]), obs_all, exp_vec(temp_exp[t]));
      end

      // fire preemption, then lockout protects the aborted window grant
      do_reset();
      sw = 1'b1;
      step();
      check("pre_idle", obs_all, exp_vec(-1));
      step();
      check("pre_w0", obs_all, exp_vec(2));
      step();
      check("pre_w1", obs_all, exp_vec(2));
      sfa = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step();
         check($sformatf("pre_%0d", i), obs_all, exp_vec(pre_exp[i]));
      end

      // full load: st flips between heat and cool each time one of them is served
      do_reset();
      sfd = 1'b1; srd = 1'b1; sw = 1'b1; sfa = 1'b1;
      st = 7'd30;
      maxgap = 0;
      ever = 6'd0;
      prev_disp = 3'd0;
      for (int k = 0; k < 4; k++) begin
         gap[k]  = 0;
         seen[k] = 1'b0;
      end
      for (int c = 0; c < 200; c++) begin
         step();
         check("load_1hot", {31'd0, $onehot0(grants)}, 32'd1);
         exp_bd = 4'd0;
         for (int k = 0; k < 6; k++)
            if (grants[k]) exp_bd = {1'b1, 3'(k + 1)};
         check("load_disp", {busy, display}, exp_bd);
         ever = ever | grants;
         for (int k = 0; k < 4; k++) begin
            if (grants[k]) begin
               seen[k] = 1'b1;
               gap[k]  = 0;
            end else if (seen[k]) begin
               gap[k]++;
               if (gap[k] > maxgap) maxgap = gap[k];
            end
         end
         if ((prev_disp == 3'd5 || prev_disp == 3'd6) && display != prev_disp)
            st = (st == 7'd30) ? 7'd100 : 7'd30;
         prev_disp = display;
      end
      check("load_all_granted", ever, 6'h3f);
      check("load_wait_le26", {31'd0, (maxgap <= 26)}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
